// File: rtl/axi_4_slave_mem.sv
// -----------------------------------------------------------------------------
// axi_4_slave_mem
//   Memory-side datapath for the AXI4 slave controller. Latches AR/AW/W
//   payloads, walks FIXED/INCR/WRAP burst addresses and holds a single-port
//   word store. The controller steps bursts with incre_counter/store_data and
//   watches data_fetched, data_stored, s_rlast and wlast_done.
//
//   Ports:
//     clk, reset                         clock, async active-high reset
//     m_ar*, s_arready                   read address channel (capture on valid&&ready)
//     m_rready, s_rdata/s_rresp/s_rlast  read data channel
//     data_fetched                       read beat available (registered)
//     m_aw*, s_awready                   write address channel
//     m_wdata/m_wstrb/m_wvalid, s_wready write data channel into holding register
//     m_bready, s_bresp                  write response
//     incre_counter                      step active burst to next beat
//     store_data                         commit held write beat
//     data_stored, wlast_done            commit status
//
//   Optional build macro: AXI_4_SLAVE_MEM_ADDR_CHECK_EN
//     Defined: out-of-range word index or burst type 2'b11 gives SLVERR,
//     reads return zero data, writes are suppressed and s_bresp is sticky.
//     Undefined: word index wraps modulo MEM_DEPTH, responses are always OKAY.
// -----------------------------------------------------------------------------
module axi_4_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   m_araddr,
    input  logic [7:0]              m_arlen,
    input  logic [1:0]              m_arburst,
    input  logic                    m_arvalid,
    input  logic                    s_arready,
    input  logic                    m_rready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    data_fetched,
    input  logic [ADDR_WIDTH-1:0]   m_awaddr,
    input  logic [7:0]              m_awlen,
    input  logic [1:0]              m_awburst,
    input  logic                    m_awvalid,
    input  logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_wvalid,
    input  logic                    s_wready,
    input  logic                    m_bready,
    output logic [1:0]              s_bresp,
    input  logic                    incre_counter,
    input  logic                    store_data,
    output logic                    data_stored,
    output logic                    wlast_done
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // WRAP keeps the high bits of the aligned container and lets only the
    // offset inside it increment; illegal WRAP lengths fall through to INCR.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = addr + ADDR_WIDTH'(STRB_W);
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << OFFS) - ADDR_WIDTH'(1);
        if (burst == BURST_FIXED)
            next_addr = addr;
        else if (burst == BURST_WRAP &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            next_addr = (addr & ~mask) | (inc & mask);
        else
            next_addr = inc;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        word_idx = IDX_W'(addr >> OFFS);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [7:0]            rd_len_q;
    logic [7:0]            rd_beat_q;
    logic [1:0]            rd_burst_q;
    logic                  rd_active_q;
    logic                  data_fetched_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [RD_LATENCY-1:0] rd_pipe_q;

    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [7:0]            wr_len_q;
    logic [7:0]            wr_beat_q;
    logic [1:0]            wr_burst_q;
    logic                  wr_active_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  data_stored_q;
    logic                  wlast_done_q;

    logic                  ar_fire, rd_incre, rd_done, rd_issue, rd_ret, rd_err;
    logic                  aw_fire, w_fire, wr_commit, wr_we, wr_incre, wr_done, wr_err;
    logic [IDX_W-1:0]      rd_idx, wr_idx;
    logic [DATA_WIDTH-1:0] rd_word_d;

    assign s_rlast      = data_fetched_q && (rd_beat_q == rd_len_q);
    assign data_fetched = data_fetched_q;
    assign s_rdata      = rdata_q;
    assign data_stored  = data_stored_q;
    assign wlast_done   = wlast_done_q;

    assign ar_fire   = m_arvalid && s_arready;
    assign rd_incre  = incre_counter && rd_active_q && data_fetched_q && !s_rlast;
    assign rd_done   = data_fetched_q && s_rlast && m_rready;
    assign rd_issue  = ar_fire || rd_incre;
    assign rd_ret    = rd_pipe_q[RD_LATENCY-1];
    assign rd_idx    = word_idx(rd_addr_q);

    assign aw_fire   = m_awvalid && s_awready;
    assign w_fire    = m_wvalid && s_wready;
    assign wr_commit = store_data && !data_stored_q;
    assign wr_we     = wr_commit && !wr_err && !reset;
    // The read engine has priority on incre_counter whenever it is active.
    assign wr_incre  = incre_counter && !rd_active_q && wr_active_q &&
                       data_stored_q && !wlast_done_q;
    assign wr_done   = wlast_done_q && m_bready;
    assign wr_idx    = word_idx(wr_addr_q);

    // Write-first bypass: a commit landing on the word being read this cycle
    // is merged into the returned data so the read sees the new bytes.
    always_comb begin
        rd_word_d = mem_q[rd_idx];
        if (wr_we && (wr_idx == rd_idx)) begin
            for (int b = 0; b < STRB_W; b++)
                if (wstrb_q[b]) rd_word_d[b*8 +: 8] = wdata_q[b*8 +: 8];
        end
    end

    // Storage is not reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_we) begin
            for (int b = 0; b < STRB_W; b++)
                if (wstrb_q[b]) mem_q[wr_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
    end

    // The issue pipe carries a token RD_LATENCY edges; its tail loads the beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_q      <= '0;
            rd_len_q       <= '0;
            rd_beat_q      <= '0;
            rd_burst_q     <= '0;
            rd_active_q    <= 1'b0;
            data_fetched_q <= 1'b0;
            rdata_q        <= '0;
            rd_pipe_q      <= '0;
        end else begin
            rd_pipe_q <= RD_LATENCY'({rd_pipe_q, rd_issue});
            if (rd_ret) begin
                data_fetched_q <= 1'b1;
                rdata_q        <= rd_err ? '0 : rd_word_d;
            end
            if (rd_incre) begin
                rd_beat_q      <= rd_beat_q + 8'd1;
                rd_addr_q      <= next_addr(rd_addr_q, rd_len_q, rd_burst_q);
                data_fetched_q <= 1'b0;
            end
            if (rd_done) begin
                data_fetched_q <= 1'b0;
                rdata_q        <= '0;
                rd_active_q    <= 1'b0;
            end
            if (ar_fire) begin
                rd_addr_q   <= m_araddr;
                rd_len_q    <= m_arlen;
                rd_burst_q  <= m_arburst;
                rd_beat_q   <= '0;
                rd_active_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr_q     <= '0;
            wr_len_q      <= '0;
            wr_beat_q     <= '0;
            wr_burst_q    <= '0;
            wr_active_q   <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            data_stored_q <= 1'b0;
            wlast_done_q  <= 1'b0;
        end else begin
            if (w_fire) begin
                wdata_q <= m_wdata;
                wstrb_q <= m_wstrb;
            end
            if (wr_commit) begin
                data_stored_q <= 1'b1;
                wlast_done_q  <= (wr_beat_q == wr_len_q);
            end
            if (wr_incre) begin
                wr_beat_q     <= wr_beat_q + 8'd1;
                wr_addr_q     <= next_addr(wr_addr_q, wr_len_q, wr_burst_q);
                data_stored_q <= 1'b0;
            end
            if (wr_done) begin
                data_stored_q <= 1'b0;
                wlast_done_q  <= 1'b0;
                wr_active_q   <= 1'b0;
            end
            if (aw_fire) begin
                wr_addr_q   <= m_awaddr;
                wr_len_q    <= m_awlen;
                wr_burst_q  <= m_awburst;
                wr_beat_q   <= '0;
                wr_active_q <= 1'b1;
            end
        end
    end

`ifdef AXI_4_SLAVE_MEM_ADDR_CHECK_EN
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic addr_err(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [1:0]            burst
    );
        addr_err = ((addr >> OFFS) >= ADDR_WIDTH'(MEM_DEPTH)) || (burst == 2'b11);
    endfunction

    logic [1:0] rresp_q;
    logic [1:0] bresp_q;

    assign rd_err  = addr_err(rd_addr_q, rd_burst_q);
    assign wr_err  = addr_err(wr_addr_q, wr_burst_q);
    assign s_rresp = rresp_q;
    assign s_bresp = bresp_q;

    // Write error stays set for the rest of the burst once any beat faults.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rresp_q <= 2'b00;
            bresp_q <= 2'b00;
        end else begin
            if (rd_ret)
                rresp_q <= rd_err ? RESP_SLVERR : 2'b00;
            if (rd_incre || rd_done)
                rresp_q <= 2'b00;
            if (wr_commit && wr_err)
                bresp_q <= RESP_SLVERR;
            if (wr_done)
                bresp_q <= 2'b00;
        end
    end
`else
    assign rd_err  = 1'b0;
    assign wr_err  = 1'b0;
    assign s_rresp = 2'b00;
    assign s_bresp = 2'b00;
`endif

endmodule

// File: tb/tb_axi_4_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_axi_4_slave_mem
//   Self-checking bench for axi_4_slave_mem. Plays the controller role, keeps a
//   word-array reference model with burst addresses computed arithmetically,
//   and runs a vector table, hand-written corner sequences and random bursts.
// -----------------------------------------------------------------------------
module tb_axi_4_slave_mem;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;
`ifdef AXI_4_SLAVE_MEM_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] m_araddr, m_awaddr;
    logic [7:0]    m_arlen, m_awlen;
    logic [1:0]    m_arburst, m_awburst;
    logic          m_arvalid, s_arready, m_rready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp, s_bresp;
    logic          s_rlast, data_fetched;
    logic          m_awvalid, s_awready;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_wvalid, s_wready, m_bready;
    logic          incre_counter, store_data, data_stored, wlast_done;
    logic [39:0]   outs;

    always #5 clk = ~clk;

    axi_4_slave_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .s_arready(s_arready), .m_rready(m_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .data_fetched(data_fetched),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .s_awready(s_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
        .s_wready(s_wready), .m_bready(m_bready), .s_bresp(s_bresp),
        .incre_counter(incre_counter), .store_data(store_data),
        .data_stored(data_stored), .wlast_done(wlast_done)
    );

    assign outs = {s_rdata, s_rresp, s_rlast, data_fetched, s_bresp, data_stored, wlast_done};

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model  [DEPTH];
    logic [31:0] wrData [256];
    logic [3:0]  wrStrb [256];

    typedef struct packed {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [1:0]       burst;
        logic [3:0][31:0] expAddr;
    } vec_t;

    // Bench-side view of the burst rules: the i-th beat address as plain
    // arithmetic on the start address and the container size.
    function automatic logic [31:0] beatAddr(input logic [31:0] start, input int len,
                                             input logic [1:0] burst, input int i);
        logic [31:0] size, base;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            size = 32'((len + 1) * 4);
            base = start - (start % size);
            return base + ((start - base + 32'(i * 4)) % size);
        end
        return start + 32'(i * 4);
    endfunction

    function automatic int wordOf(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit isErr(input logic [31:0] a, input logic [1:0] b);
        return CHECK_EN && (((a >> 2) >= 32'(DEPTH)) || (b == 2'b11));
    endfunction

    function automatic void modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) model[wordOf(a)][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write burst: AW and first W on one edge, then store / step per beat.
    task automatic writeBurst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                              input bit checkFlags);
        logic [31:0] a;
        bit          errSeen;
        errSeen   = 1'b0;
        m_awaddr  = addr; m_awlen = 8'(len); m_awburst = burst;
        m_awvalid = 1'b1; s_awready = 1'b1;
        m_wdata   = wrData[0]; m_wstrb = wrStrb[0]; m_wvalid = 1'b1; s_wready = 1'b1;
        tick();
        m_awvalid = 1'b0; s_awready = 1'b0; m_wvalid = 1'b0; s_wready = 1'b0;
        for (int i = 0; i <= len; i++) begin
            store_data = 1'b1;
            tick();
            store_data = 1'b0;
            a = beatAddr(addr, len, burst, i);
            if (isErr(a, burst)) errSeen = 1'b1;
            else modelWrite(a, wrData[i], wrStrb[i]);
            if (checkFlags) begin
                checkOutput("data_stored", 64'(data_stored), 64'(1));
                checkOutput("wlast_done", 64'(wlast_done), 64'(i == len));
            end
            if (i < len) begin
                incre_counter = 1'b1;
                m_wdata = wrData[i+1]; m_wstrb = wrStrb[i+1]; m_wvalid = 1'b1; s_wready = 1'b1;
                tick();
                incre_counter = 1'b0; m_wvalid = 1'b0; s_wready = 1'b0;
                if (checkFlags) checkOutput("stored cleared", 64'(data_stored), 64'(0));
            end
        end
        if (checkFlags) checkOutput("bresp", 64'(s_bresp), errSeen ? 64'(2) : 64'(0));
        m_bready = 1'b1;
        tick();
        m_bready = 1'b0;
        if (checkFlags) checkOutput("write done", 64'({data_stored, wlast_done, s_bresp}), 64'(0));
    endtask

    // Read burst: every beat checked for data, response, last flag and the
    // number of cycles data_fetched stayed low before it.
    task automatic readBurst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input int hold, output logic [31:0] lastData);
        int          cyc;
        logic [31:0] a, expData;
        logic [1:0]  expResp;
        lastData  = '0;
        m_araddr  = addr; m_arlen = 8'(len); m_arburst = burst;
        m_arvalid = 1'b1; s_arready = 1'b1;
        tick();
        m_arvalid = 1'b0; s_arready = 1'b0;
        for (int i = 0; i <= len; i++) begin
            cyc = 0;
            while (data_fetched !== 1'b1 && cyc < 20) begin
                tick();
                cyc++;
            end
            if (data_fetched !== 1'b1) begin
                checkOutput("read beat timeout", 64'(0), 64'(1));
                return;
            end
            checkOutput("fetch gap", 64'(cyc), 64'(LAT));
            a = beatAddr(addr, len, burst, i);
            if (isErr(a, burst)) begin expData = '0; expResp = 2'b10; end
            else begin expData = model[wordOf(a)]; expResp = 2'b00; end
            checkOutput("rdata", 64'(s_rdata), 64'(expData));
            checkOutput("rresp", 64'(s_rresp), 64'(expResp));
            checkOutput("rlast", 64'(s_rlast), 64'(i == len));
            lastData = s_rdata;
            if (i < len) begin
                incre_counter = 1'b1;
                tick();
                incre_counter = 1'b0;
            end else begin
                for (int h = 0; h < hold; h++) begin
                    tick();
                    checkOutput("rready hold", 64'({data_fetched, s_rlast, s_rdata}),
                                64'({1'b1, 1'b1, expData}));
                end
                m_rready = 1'b1;
                tick();
                m_rready = 1'b0;
                checkOutput("read done", 64'({data_fetched, s_rlast, s_rdata}), 64'(0));
            end
        end
    endtask

    // One table vector: write the burst, then read each expected beat address
    // singly and expect the data of the last beat that hit it.
    task automatic applyStimulus(input vec_t vec, input int v);
        int          len;
        logic [31:0] exp, got;
        len = int'(vec.len);
        for (int i = 0; i <= len; i++) begin
            wrData[i] = 32'hC0DE0000 | 32'(v << 8) | 32'(i);
            wrStrb[i] = 4'hF;
        end
        writeBurst(vec.addr, len, vec.burst, 1'b1);
        for (int i = 0; i <= len; i++) begin
            exp = wrData[i];
            for (int j = i + 1; j <= len; j++)
                if (vec.expAddr[j] == vec.expAddr[i]) exp = wrData[j];
            readBurst(vec.expAddr[i], 0, 2'b01, 0, got);
            checkOutput("vector readback", 64'(got), 64'(exp));
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [7];
        logic [31:0] got, addr;
        int          len;
        logic [1:0]  burst;

        vecs[0] = '{addr: 32'h38,  len: 8'd3, burst: 2'b10, expAddr: {32'h34,  32'h30,  32'h3C,  32'h38}};
        vecs[1] = '{addr: 32'h100, len: 8'd3, burst: 2'b01, expAddr: {32'h10C, 32'h108, 32'h104, 32'h100}};
        vecs[2] = '{addr: 32'h200, len: 8'd2, burst: 2'b00, expAddr: {32'h0,   32'h200, 32'h200, 32'h200}};
        vecs[3] = '{addr: 32'h204, len: 8'd1, burst: 2'b10, expAddr: {32'h0,   32'h0,   32'h200, 32'h204}};
        vecs[4] = '{addr: 32'h308, len: 8'd2, burst: 2'b10, expAddr: {32'h0,   32'h310, 32'h30C, 32'h308}};
        vecs[5] = '{addr: 32'h404, len: 8'd1, burst: 2'b11, expAddr: {32'h0,   32'h0,   32'h408, 32'h404}};
        vecs[6] = '{addr: 32'h3C,  len: 8'd3, burst: 2'b10, expAddr: {32'h38,  32'h34,  32'h30,  32'h3C}};

        reset = 1'b1;
        m_araddr = '0; m_arlen = '0; m_arburst = '0; m_arvalid = 1'b0; s_arready = 1'b0;
        m_rready = 1'b0; m_awaddr = '0; m_awlen = '0; m_awburst = '0; m_awvalid = 1'b0;
        s_awready = 1'b0; m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0; s_wready = 1'b0;
        m_bready = 1'b0; incre_counter = 1'b0; store_data = 1'b0;
        repeat (3) tick();
        checkOutput("reset outputs", 64'(outs), 64'(0));
        reset = 1'b0;
        tick();

        // Fill the whole store so every later read has a known model value.
        for (int blk = 0; blk < DEPTH / 256; blk++) begin
            for (int i = 0; i < 256; i++) begin
                wrData[i] = $urandom;
                wrStrb[i] = 4'hF;
            end
            writeBurst(32'(blk * 1024), 255, 2'b01, 1'b0);
        end

        $display("[TB] INCR read of preloaded words");
        for (int i = 0; i < 4; i++) begin
            wrData[i] = 32'hA0 + 32'(i);
            wrStrb[i] = 4'hF;
        end
        writeBurst(32'h40, 3, 2'b01, 1'b1);
        readBurst(32'h40, 3, 2'b01, 0, got);
        checkOutput("incr last beat", 64'(got), 64'(32'hA3));

        $display("[TB] vector table");
        for (int v = 0; v < 7; v++)
            if (!(CHECK_EN && vecs[v].burst == 2'b11))
                applyStimulus(vecs[v], v);

        $display("[TB] byte strobes");
        wrData[0] = 32'hFFFFFFFF; wrStrb[0] = 4'hF;
        writeBurst(32'h500, 0, 2'b01, 1'b1);
        wrData[0] = 32'h12345678; wrStrb[0] = 4'b0101;
        writeBurst(32'h500, 0, 2'b01, 1'b1);
        readBurst(32'h500, 0, 2'b01, 0, got);
        checkOutput("strobe merge", 64'(got), 64'(32'hFF34FF78));

        $display("[TB] FIXED read and rready backpressure");
        readBurst(32'h08, 2, 2'b00, 0, got);
        readBurst(32'h80, 1, 2'b01, 5, got);

        $display("[TB] random bursts");
        for (int n = 0; n < 40; n++) begin
            addr  = 32'($urandom_range(0, 32'h1FFF));
            len   = int'($urandom_range(0, 15));
            burst = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin
                    wrData[i] = $urandom;
                    wrStrb[i] = 4'($urandom);
                end
                writeBurst(addr, len, burst, 1'b1);
            end else begin
                readBurst(addr, len, burst, int'($urandom_range(0, 2)), got);
            end
        end

        $display("[TB] reset in the middle of a write burst");
        wrData[0] = 32'hBEEF0000; wrData[1] = 32'hBEEF0001;
        m_awaddr = 32'h600; m_awlen = 8'd3; m_awburst = 2'b01; m_awvalid = 1'b1; s_awready = 1'b1;
        m_wdata = wrData[0]; m_wstrb = 4'hF; m_wvalid = 1'b1; s_wready = 1'b1;
        tick();
        m_awvalid = 1'b0; s_awready = 1'b0; m_wvalid = 1'b0; s_wready = 1'b0;
        store_data = 1'b1;
        tick();
        store_data = 1'b0;
        checkOutput("stored before reset", 64'(data_stored), 64'(1));
        incre_counter = 1'b1; m_wdata = wrData[1]; m_wvalid = 1'b1; s_wready = 1'b1;
        tick();
        incre_counter = 1'b0; m_wvalid = 1'b0; s_wready = 1'b0;
        #2 reset = 1'b1;
        #1 checkOutput("outputs in reset", 64'(outs), 64'(0));
        tick();
        reset = 1'b0;
        tick();
        modelWrite(32'h600, wrData[0], 4'hF);
        readBurst(32'h600, 1, 2'b01, 0, got);
        readBurst(32'h600, 0, 2'b01, 0, got);
        checkOutput("beat0 retained", 64'(got), 64'(32'hBEEF0000));

`ifdef AXI_4_SLAVE_MEM_ADDR_CHECK_EN
        $display("[TB] out-of-range read");
        readBurst(32'(DEPTH * 4), 0, 2'b01, 0, got);
        checkOutput("oob rdata", 64'(got), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_4_slave_mem.md
Name: axi_4_slave_mem

Overview:
- Memory-side datapath and storage that sits directly downstream of the AXI4 slave controller. It latches AR/AW/W channel payloads, generates FIXED/INCR/WRAP burst word addresses and keeps single-port word storage. It consumes incre_counter/store_data and produces the data_fetched, data_stored, s_rlast and wlast_done status that drive the controller's FSM.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, beat width; every beat is full width (no AxSIZE); byte offset bits = log2(DATA_WIDTH/8).
- MEM_DEPTH, 1024, words of storage; power of 2.
- RD_LATENCY, 1, cycles from read issue to data_fetched; must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m_araddr  in  ADDR_WIDTH  read burst start byte address
- m_arlen  in  8  read beats minus 1
- m_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- m_arvalid  in  1  read address valid
- s_arready  in  1  from controller; AR captured on m_arvalid && s_arready
- m_rready  in  1  master accepts read beat
- s_rdata  out  DATA_WIDTH  read beat data
- s_rresp  out  2  read beat response
- s_rlast  out  1  current read beat is last
- data_fetched  out  1  read beat available
- m_awaddr  in  ADDR_WIDTH  write burst start byte address
- m_awlen  in  8  write beats minus 1
- m_awburst  in  2  write burst type
- m_awvalid  in  1  write address valid
- s_awready  in  1  from controller; AW captured on m_awvalid && s_awready
- m_wdata  in  DATA_WIDTH  write beat data
- m_wstrb  in  DATA_WIDTH/8  byte enables
- m_wvalid  in  1  write data valid
- s_wready  in  1  from controller; W captured on m_wvalid && s_wready
- m_bready  in  1  master accepts write response
- s_bresp  out  2  write burst response
- incre_counter  in  1  advance active burst to next beat
- store_data  in  1  commit held write beat
- data_stored  out  1  held write beat committed
- wlast_done  out  1  final write beat committed

Behaviour:
- Reset: async, active-high. It clears s_rdata, s_rresp, s_rlast, data_fetched, s_bresp, data_stored, wlast_done, beat counters, addresses and active flags to 0, and flushes the read pipeline. An in-flight write beat is dropped. Storage contents are not cleared.
- Read engine:
  - On AR capture at edge T0, it latches address, length and burst type, clears rd_beat, sets rd_active and issues a read.
  - data_fetched is registered. It rises at T0+RD_LATENCY with s_rdata valid, and s_rdata is held stable while data_fetched is 1.
  - s_rlast = data_fetched && (rd_beat == rd_len).
  - incre_counter while data_fetched && !s_rlast: rd_beat++, address advances, data_fetched clears at that edge and returns RD_LATENCY cycles later.
  - Completion when data_fetched && s_rlast && m_rready: all read outputs clear and rd_active drops.
- Write engine:
  - AW capture latches address, length and burst type, clears wr_beat and sets wr_active.
  - Each W capture loads a wdata/wstrb holding register; AW and W may be captured on the same edge.
  - store_data && !data_stored: storage word written byte-wise per wstrb. data_stored and wlast_done (= wr_beat == wr_len) register to 1 on the next edge and hold.
  - incre_counter while data_stored && !wlast_done: wr_beat++, address advances, data_stored clears.
  - Completion when wlast_done && m_bready: data_stored, wlast_done, s_bresp and wr_active clear.
- Address generation:
  - FIXED: address unchanged.
  - INCR: address += DATA_WIDTH/8.
  - WRAP: container = (len+1)*DATA_WIDTH/8 aligned down; address increments and wraps to the container base. Legal WRAP lengths are 2/4/8/16 beats; other lengths are treated as INCR.
  - Word index = address >> byte-offset bits.
- incre_counter routing: applies to the active engine; if both rd_active and wr_active, the read engine takes it.
- Simultaneous storage access: a write commit and a read issue in the same cycle are both performed; write first, and the read returns the newly written word.

Optional Feature:
- AXI_4_SLAVE_MEM_ADDR_CHECK_EN defined: word index >= MEM_DEPTH, or burst 2'b11, gives SLVERR (2'b10). Reads return s_rdata = 0 with s_rresp = 10 for that beat. Writes are suppressed and s_bresp = 10, sticky until burst completion.
- Not defined: index taken modulo MEM_DEPTH, burst 11 treated as INCR, s_rresp/s_bresp always 2'b00.

Test Plan:
1. Preload words 0x10..0x13 = A0..A3, INCR read araddr 0x40 arlen 3 -> beats A0,A1,A2,A3, s_rlast only on 4th, s_rresp 00.
2. WRAP write awaddr 0x38 awlen 3 wdata 1,2,3,4 wstrb F -> words at 0x38,0x3C,0x30,0x34 = 1,2,3,4; wlast_done on 4th beat only.
3. Word = 0xFFFFFFFF, single write 0x12345678 wstrb 4'b0101 -> read back 0xFF34FF78.
4. FIXED read araddr 0x08 arlen 2 -> same word returned 3 times; RD_LATENCY=3 -> data_fetched low exactly 3 cycles between beats.
5. m_rready low 5 cycles on beat 1 -> data_fetched, s_rdata, s_rlast held unchanged.
6. Reset asserted mid write burst after beat 1 -> all outputs 0 at reset; beat 0 data retained, beat 1 not written. With macro, araddr = MEM_DEPTH*4 -> s_rresp 10, s_rdata 0.
